// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: turns the fetch stage's req/addr_ok/data_ok instruction
// interface into single-beat AXI4 reads, returning data in order.
// Optional feature macro INST_BRIDGE_OUT2_EN: allows two reads in flight
// (otherwise only one read may be outstanding).
module inst_axi_rd_bridge #(
  parameter int              ID_W     = 4,
  parameter logic [ID_W-1:0] ARID_VAL = '0
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            inst_sram_req,
  input  logic            inst_sram_wr,
  input  logic [1:0]      inst_sram_size,
  input  logic [31:0]     inst_sram_addr,
  input  logic [3:0]      inst_sram_wstrb,
  input  logic [31:0]     inst_sram_wdata,
  output logic            inst_sram_addr_ok,
  output logic            inst_sram_data_ok,
  output logic [31:0]     inst_sram_rdata,
  output logic [ID_W-1:0] arid,
  output logic [31:0]     araddr,
  output logic [7:0]      arlen,
  output logic [2:0]      arsize,
  output logic [1:0]      arburst,
  output logic [1:0]      arlock,
  output logic [3:0]      arcache,
  output logic [2:0]      arprot,
  output logic            arvalid,
  input  logic            arready,
  input  logic [ID_W-1:0] rid,
  input  logic [31:0]     rdata,
  input  logic [1:0]      rresp,
  input  logic            rlast,
  input  logic            rvalid,
  output logic            rready,
  output logic [ID_W-1:0] axi_arid
);

`ifdef INST_BRIDGE_OUT2_EN
  localparam logic [1:0] MAX_OUT = 2'd2;
`else
  localparam logic [1:0] MAX_OUT = 2'd1;
`endif

  typedef enum logic {AR_IDLE = 1'b0, AR_SEND = 1'b1} ar_state_t;

  ar_state_t   state_reg, state_next;
  logic [1:0]  cnt_reg, cnt_next;
  logic [31:0] ar_addr_r;
  logic [1:0]  ar_size_r;
  logic        data_ok_r;
  logic [31:0] rdata_r;
  logic        r_accept;

  // Write-side fields and R-channel status are deliberately ignored.
  logic unused_inputs;
  assign unused_inputs = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata, rresp, rlast};

  // Fixed single-beat incrementing read attributes.
  assign arid    = ARID_VAL;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign araddr  = ar_addr_r;
  assign arsize  = {1'b0, ar_size_r};

  // Only beats carrying our own ID count as responses; foreign IDs are sunk.
  assign rready            = (cnt_reg != 2'd0);
  assign r_accept          = rvalid & rready & (rid == ARID_VAL);
  assign inst_sram_data_ok = data_ok_r;
  assign inst_sram_rdata   = rdata_r;

  // AR FSM next state: accept in IDLE while a slot is free, present in SEND.
  always_comb begin
    state_next        = state_reg;
    inst_sram_addr_ok = 1'b0;
    arvalid           = 1'b0;
    case (state_reg)
      AR_IDLE: begin
        inst_sram_addr_ok = inst_sram_req & (cnt_reg < MAX_OUT);
        if (inst_sram_addr_ok) state_next = AR_SEND;
      end
      AR_SEND: begin
        arvalid = 1'b1;
        if (arready) state_next = AR_IDLE;
      end
      default: state_next = AR_IDLE;
    endcase
  end

  // Outstanding count: a new request and a returning beat in one cycle cancel out.
  always_comb begin
    cnt_next = cnt_reg;
    case ({inst_sram_addr_ok, r_accept})
      2'b10:   cnt_next = cnt_reg + 2'd1;
      2'b01:   cnt_next = cnt_reg - 2'd1;
      default: cnt_next = cnt_reg;
    endcase
  end

  // FSM state and outstanding counter registers.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg <= AR_IDLE;
      cnt_reg   <= 2'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the accepted request so AR stays stable until the handshake.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      ar_addr_r <= 32'd0;
      ar_size_r <= 2'd0;
      axi_arid  <= '0;
    end else if (inst_sram_addr_ok) begin
      ar_addr_r <= inst_sram_addr;
      ar_size_r <= inst_sram_size;
      axi_arid  <= ARID_VAL;
    end
  end

  // Register returned data; data_ok pulses one cycle per accepted beat.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_ok_r <= 1'b0;
      rdata_r   <= 32'd0;
    end else begin
      data_ok_r <= r_accept;
      if (r_accept) rdata_r <= rdata;
    end
  end

endmodule
